ramdisk_mapper: RTL and testbench



---
 rtl/ramdisk_mapper.sv | 235 +++++++++++++++++++++++
 tb/tb_ramdisk_mapper.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ramdisk_mapper.sv
`default_nettype none
// ============================================================================
//  Module   : ramdisk_mapper
//  Brief    : Multi-channel RAM-disk window for the K580 bus. Each channel owns
//             a linear address register and a DATA port. Every DATA access
//             issues one request to the SDRAM arbiter and stalls the CPU
//             through `ready` until the arbiter acknowledges it.
//             Optional macro RAMDISK_AUTOINC_EN adds a per-channel
//             auto-increment flag (reg3 bit 7).
//  Revision : 1.0 - initial release
// ============================================================================
module ramdisk_mapper #(
    parameter int               ADDR_W   = 19,
    parameter int               CHANNELS = 1,
    parameter int               MEM_W    = 25,
    parameter logic [MEM_W-1:0] BASE     = 25'h1000000
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             sel,
    input  logic [3:0]       iaddr,
    input  logic             wr_stb,
    input  logic             rd_stb,
    input  logic [7:0]       idata,
    output logic [7:0]       odata,
    output logic             ready,
    output logic             err,
    output logic             mem_req,
    output logic             mem_we,
    output logic [MEM_W-1:0] mem_addr,
    output logic [7:0]       mem_din,
    input  logic [7:0]       mem_dout,
    input  logic             mem_ack
);

    // Number of address bits held in reg3.
    localparam int HI_W  = ADDR_W - 16;
    // Adder width: wide enough for both the base and {channel, address}.
    localparam int SUM_W = (MEM_W > ADDR_W + 2) ? MEM_W : ADDR_W + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q [4];
    logic [ADDR_W-1:0] addr_d [4];
    logic [7:0]        odata_q, odata_d;
    logic              err_q, err_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [MEM_W-1:0]  mem_addr_q, mem_addr_d;
    logic [7:0]        mem_din_q, mem_din_d;

`ifdef RAMDISK_AUTOINC_EN
    logic [3:0]        inc_q, inc_d;
    logic [1:0]        ch_q, ch_d;
`endif

    logic [1:0]        w_ch;
    logic [1:0]        w_reg;
    logic              w_ch_ok;
    logic              w_any;
    logic              w_is_wr;
    logic              w_both;
    logic [ADDR_W-1:0] w_cur_a;
    logic              w_inc_bit;
    logic [7:0]        w_hi;
    logic [7:0]        w_rd_val;
    logic [SUM_W-1:0]  w_sum;

    assign w_ch    = iaddr[3:2];
    assign w_reg   = iaddr[1:0];
    assign w_ch_ok = (int'(w_ch) < CHANNELS);
    assign w_any   = sel & (rd_stb | wr_stb);
    assign w_is_wr = sel & wr_stb;
    assign w_both  = sel & rd_stb & wr_stb;
    assign w_cur_a = addr_q[w_ch];
    assign w_sum   = SUM_W'(BASE) + SUM_W'({w_ch, w_cur_a});

`ifdef RAMDISK_AUTOINC_EN
    assign w_inc_bit = inc_q[w_ch];
`else
    assign w_inc_bit = 1'b0;
`endif

    // Read-back value of the addressed address register.
    always_comb begin
        w_hi             = '0;
        w_hi[HI_W-1:0]   = w_cur_a[ADDR_W-1:16];
        w_hi[7]          = w_inc_bit;
        case (w_reg)
            2'd1:    w_rd_val = w_cur_a[7:0];
            2'd2:    w_rd_val = w_cur_a[15:8];
            2'd3:    w_rd_val = w_hi;
            default: w_rd_val = 8'h00;
        endcase
    end

    // Next-state, register-file and memory-request logic.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        odata_d    = odata_q;
        err_d      = err_q;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
`ifdef RAMDISK_AUTOINC_EN
        inc_d      = inc_q;
        ch_d       = ch_q;
`endif
        case (state_q)
            IDLE: begin
                if (w_any) begin
                    // Both strobes at once: the write is taken, but flagged.
                    if (w_both) begin
                        err_d = 1'b1;
                    end
                    if (!w_ch_ok) begin
                        err_d = 1'b1;
                        if (!w_is_wr) begin
                            odata_d = 8'hFF;
                        end
                    end else if (w_reg == 2'd0) begin
                        state_d    = REQ;
                        mem_req_d  = 1'b1;
                        mem_we_d   = w_is_wr;
                        mem_addr_d = w_sum[MEM_W-1:0];
                        if (w_is_wr) begin
                            mem_din_d = idata;
                        end
`ifdef RAMDISK_AUTOINC_EN
                        ch_d = w_ch;
`endif
                    end else if (w_is_wr) begin
                        case (w_reg)
                            2'd1: addr_d[w_ch][7:0]  = idata;
                            2'd2: addr_d[w_ch][15:8] = idata;
                            default: begin
                                addr_d[w_ch][ADDR_W-1:16] = idata[HI_W-1:0];
`ifdef RAMDISK_AUTOINC_EN
                                inc_d[w_ch] = idata[7];
`endif
                            end
                        endcase
                    end else begin
                        odata_d = w_rd_val;
                    end
                end
            end
            REQ: begin
                if (w_any) begin
                    err_d = 1'b1;
                end
                if (mem_ack) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        odata_d = mem_dout;
                    end
                end
            end
            DONE: begin
                if (w_any) begin
                    err_d = 1'b1;
                end
                state_d = IDLE;
`ifdef RAMDISK_AUTOINC_EN
                if (inc_q[ch_q]) begin
                    addr_d[ch_q] = addr_q[ch_q] + 1'b1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Channels beyond CHANNELS carry no storage.
        for (int c = 0; c < 4; c++) begin
            if (c >= CHANNELS) begin
                addr_d[c] = '0;
`ifdef RAMDISK_AUTOINC_EN
                inc_d[c]  = 1'b0;
`endif
            end
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= IDLE;
            for (int c = 0; c < 4; c++) begin
                addr_q[c] <= '0;
            end
            odata_q    <= 8'h00;
            err_q      <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= BASE;
            mem_din_q  <= 8'h00;
`ifdef RAMDISK_AUTOINC_EN
            inc_q      <= 4'h0;
            ch_q       <= 2'd0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            odata_q    <= odata_d;
            err_q      <= err_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
`ifdef RAMDISK_AUTOINC_EN
            inc_q      <= inc_d;
            ch_q       <= ch_d;
`endif
        end
    end

    assign odata    = odata_q;
    assign ready    = (state_q == IDLE);
    assign err      = err_q;
    assign mem_req  = mem_req_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;

endmodule
`default_nettype wire

// File: tb/tb_ramdisk_mapper.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ramdisk_mapper
//  Brief    : Directed plus randomized bench for ramdisk_mapper (2 channels)
//             against a behavioural model of the register window.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ramdisk_mapper;

    localparam int          ADDR_W   = 19;
    localparam int          CHANNELS = 2;
    localparam int          MEM_W    = 25;
    localparam logic [24:0] BASE     = 25'h1000000;

    logic        clk_sys = 1'b0;
    logic        reset, sel, wr_stb, rd_stb, mem_ack;
    logic [3:0]  iaddr;
    logic [7:0]  idata, mem_dout;
    logic [7:0]  odata, mem_din;
    logic        ready, err, mem_req, mem_we;
    logic [24:0] mem_addr;

    ramdisk_mapper #(
        .ADDR_W   (ADDR_W),
        .CHANNELS (CHANNELS),
        .MEM_W    (MEM_W),
        .BASE     (BASE)
    ) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .sel      (sel),
        .iaddr    (iaddr),
        .wr_stb   (wr_stb),
        .rd_stb   (rd_stb),
        .idata    (idata),
        .odata    (odata),
        .ready    (ready),
        .err      (err),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout),
        .mem_ack  (mem_ack)
    );

    always #5 clk_sys = ~clk_sys;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    // Behavioural model state
    longint     m_a   [4];
    bit         m_inc [4];
    bit         m_err;
    logic [7:0] m_odata;
    logic [7:0] m_din;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic m_reset();
        for (int c = 0; c < 4; c++) begin
            m_a[c]   = 0;
            m_inc[c] = 1'b0;
        end
        m_err   = 1'b0;
        m_odata = 8'h00;
        m_din   = 8'h00;
    endtask

    function automatic logic [31:0] m_addr(input int ch);
        longint v;
        v = (longint'(BASE) + longint'(ch) * (longint'(1) << ADDR_W) + m_a[ch])
            % (longint'(1) << MEM_W);
        return 32'(v);
    endfunction

    function automatic logic [7:0] m_reg(input int ch, input int rg);
        longint v;
        case (rg)
            1:       v = m_a[ch] % 256;
            2:       v = (m_a[ch] / 256) % 256;
            default: v = m_a[ch] / 65536 + (m_inc[ch] ? 128 : 0);
        endcase
        return 8'(v);
    endfunction

    task automatic m_write(input int ch, input int rg, input logic [7:0] d);
        longint dv;
        dv = longint'(d);
        case (rg)
            1: m_a[ch] = m_a[ch] - (m_a[ch] % 256) + dv;
            2: m_a[ch] = m_a[ch] - ((m_a[ch] / 256) % 256) * 256 + dv * 256;
            default: begin
                m_a[ch] = (m_a[ch] % 65536) + (dv % (longint'(1) << (ADDR_W - 16))) * 65536;
`ifdef RAMDISK_AUTOINC_EN
                m_inc[ch] = (dv >= 128);
`endif
            end
        endcase
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".ready"}, 32'(ready), 32'(1));
        check({tag, ".req"},   32'(mem_req), 32'(0));
        check({tag, ".odata"}, 32'(odata), 32'(m_odata));
        check({tag, ".err"},   32'(err), 32'(m_err));
    endtask

    // One CPU access, with the arbiter acknowledging after ack_dly extra
    // REQ cycles. drop_at >= 0 injects a second write strobe mid-request.
    task automatic access(input bit is_wr, input bit is_rd, input int ch, input int rg,
                          input logic [7:0] d, input int ack_dly, input logic [7:0] dout,
                          input int drop_at);
        logic [31:0] exp_addr;
        sel    = 1'b1;
        wr_stb = is_wr;
        rd_stb = is_rd;
        iaddr  = {2'(ch), 2'(rg)};
        idata  = d;
        tick();
        sel    = 1'b0;
        wr_stb = 1'b0;
        rd_stb = 1'b0;
        if (is_wr && is_rd) m_err = 1'b1;
        if (ch >= CHANNELS) begin
            m_err = 1'b1;
            if (!is_wr) m_odata = 8'hFF;
            check_idle("badch");
        end else if (rg != 0) begin
            if (is_wr) m_write(ch, rg, d);
            else       m_odata = m_reg(ch, rg);
            check_idle("areg");
        end else begin
            exp_addr = m_addr(ch);
            if (is_wr) m_din = d;
            for (int i = 0; i <= ack_dly; i++) begin
                check("req.req",   32'(mem_req), 32'(1));
                check("req.we",    32'(mem_we), 32'(is_wr));
                check("req.addr",  32'(mem_addr), exp_addr);
                check("req.din",   32'(mem_din), 32'(m_din));
                check("req.ready", 32'(ready), 32'(0));
                if (i == drop_at) begin
                    sel    = 1'b1;
                    wr_stb = 1'b1;
                    idata  = ~d;
                    iaddr  = 4'($urandom_range(0, 15));
                    m_err  = 1'b1;
                end
                if (i == ack_dly) begin
                    mem_ack  = 1'b1;
                    mem_dout = dout;
                end
                tick();
                sel      = 1'b0;
                wr_stb   = 1'b0;
                mem_ack  = 1'b0;
                mem_dout = 8'($urandom_range(0, 255));
            end
            if (!is_wr) m_odata = dout;
            check("done.ready", 32'(ready), 32'(0));
            check("done.req",   32'(mem_req), 32'(0));
            check("done.odata", 32'(odata), 32'(m_odata));
            check("done.err",   32'(err), 32'(m_err));
            tick();
            if (m_inc[ch]) m_a[ch] = (m_a[ch] + 1) % (longint'(1) << ADDR_W);
            check("post.ready", 32'(ready), 32'(1));
            check("post.din",   32'(mem_din), 32'(m_din));
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; sel = 1'b0; wr_stb = 1'b0; rd_stb = 1'b0; mem_ack = 1'b0;
        iaddr = 4'h0; idata = 8'h00; mem_dout = 8'h00;
        m_reset();
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Reset state
        check_idle("rst");
        check("rst.addr", 32'(mem_addr), 32'h1000000);
        check("rst.din",  32'(mem_din), 32'(0));

        // Channel 0, A = 12345h, DATA write 5Ah, ack after 4 cycles
        access(1, 0, 0, 3, 8'h01, 0, 8'h00, -1);
        access(1, 0, 0, 2, 8'h23, 0, 8'h00, -1);
        access(1, 0, 0, 1, 8'h45, 0, 8'h00, -1);
        check("a0.addr", m_addr(0), 32'h1012345);
        access(1, 0, 0, 0, 8'h5A, 4, 8'h00, -1);

        // Channel 1, A = 0, DATA read of C3h
        check("a1.addr", m_addr(1), 32'h1080000);
        access(0, 1, 1, 0, 8'h00, 0, 8'hC3, -1);
        access(0, 1, 1, 1, 8'h00, 0, 8'h00, -1);

`ifdef RAMDISK_AUTOINC_EN
        // Auto-increment wrap from 7FFFFh
        access(1, 0, 0, 3, 8'h87, 0, 8'h00, -1);
        access(1, 0, 0, 2, 8'hFF, 0, 8'h00, -1);
        access(1, 0, 0, 1, 8'hFF, 0, 8'h00, -1);
        check("inc.addr0", m_addr(0), 32'h107FFFF);
        access(0, 1, 0, 0, 8'h00, 1, 8'h11, -1);
        check("inc.addr1", m_addr(0), 32'h1000000);
        access(0, 1, 0, 0, 8'h00, 0, 8'h22, -1);
        access(0, 1, 0, 1, 8'h00, 0, 8'h00, -1);
        check("inc.rd1", 32'(odata), 32'h01);
        access(0, 1, 0, 3, 8'h00, 0, 8'h00, -1);
        check("inc.rd3", 32'(odata), 32'h80);
`else
        // Bit 7 of reg3 is not stored
        access(1, 0, 1, 3, 8'h85, 0, 8'h00, -1);
        access(0, 1, 1, 3, 8'h00, 0, 8'h00, -1);
        check("noinc.rd3", 32'(odata), 32'h05);
`endif

        // Dropped write strobe during REQ
        access(1, 0, 0, 0, 8'h3C, 3, 8'h00, 1);
        check("drop.err", 32'(err), 32'(1));

        // Reset during REQ, then a late ack
        sel = 1'b1; rd_stb = 1'b1; iaddr = 4'h0;
        tick();
        sel = 1'b0; rd_stb = 1'b0;
        check("mid.req", 32'(mem_req), 32'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_reset();
        check_idle("midrst");
        check("midrst.addr", 32'(mem_addr), 32'h1000000);
        mem_ack = 1'b1; mem_dout = 8'h77;
        tick();
        mem_ack = 1'b0;
        check_idle("lateack");

        // Out-of-range channel read
        access(0, 1, 3, 0, 8'h00, 0, 8'h00, -1);
        check("ch3.odata", 32'(odata), 32'hFF);
        access(1, 0, 2, 1, 8'h99, 0, 8'h00, -1);

        // Randomized traffic
        for (int n = 0; n < 250; n++) begin
            int ch, rg, mode, dly, drop;
            logic [7:0] d, dout;
            ch   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, 3))
                                               : int'($urandom_range(0, 1));
            rg   = int'($urandom_range(0, 3));
            mode = int'($urandom_range(0, 11));
            dly  = int'($urandom_range(0, 5));
            drop = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, dly)) : -1;
            d    = 8'($urandom_range(0, 255));
            dout = 8'($urandom_range(0, 255));
            if (mode == 0) begin
                access(1, 1, ch, rg, d, dly, dout, drop);
            end else if (mode == 1) begin
                wr_stb = 1'b1; rd_stb = 1'b1; iaddr = 4'($urandom_range(0, 15)); idata = d;
                tick();
                wr_stb = 1'b0; rd_stb = 1'b0;
                check_idle("nosel");
            end else if (mode < 7) begin
                access(1, 0, ch, rg, d, dly, dout, drop);
            end else begin
                access(0, 1, ch, rg, d, dly, dout, drop);
            end
        end

        // Final read-back of both channels' address registers
        for (int c = 0; c < CHANNELS; c++) begin
            for (int r = 1; r < 4; r++) begin
                access(0, 1, c, r, 8'h00, 0, 8'h00, -1);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
